// File: rtl/binary_codec_pkg.sv
// Shared definitions for the binary encoder/decoder pair.
//   enc_state_e : encoder output-stage state (EMPTY / FULL)
//   DefaultN    : default number of request lines
//   MaxN        : widest vector prio_idx() can scan
//   prio_idx()  : index of the lowest set bit (0 when the vector is all zero)
package binary_codec_pkg;

  typedef enum logic {ENC_EMPTY, ENC_FULL} enc_state_e;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned MaxN     = 32;

  function automatic int unsigned prio_idx(input logic [MaxN-1:0] vec);
    int unsigned idx;
    idx = 0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = MaxN - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational N -> log2(N) priority encoder, lowest index wins.
// Optional feature macro: MULTI_HOT_CHK_EN (adds multi_o).
//   vec_i   : request vector
//   idx_o   : index of the lowest set bit (0 when vec_i == 0)
//   none_o  : vec_i is all zero
//   multi_o : (MULTI_HOT_CHK_EN) more than one bit of vec_i is set
module prio_enc
  import binary_codec_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         none_o
`ifdef MULTI_HOT_CHK_EN
  ,
  output logic         multi_o
`endif
);

  logic [MaxN-1:0] vec_ext;

  always_comb begin
    vec_ext         = '0;
    vec_ext[N-1:0]  = vec_i;
  end

  assign idx_o  = W'(prio_idx(vec_ext));
  assign none_o = ~|vec_i;

`ifdef MULTI_HOT_CHK_EN
  // Clearing the lowest set bit leaves something iff more than one bit was set.
  assign multi_o = |(vec_i & (vec_i - {{(N-1){1'b0}}, 1'b1}));
`endif

endmodule

// File: rtl/binary_encoder.sv
// Registered priority encoder with valid/ready on both sides and one register stage.
// Optional feature macro: MULTI_HOT_CHK_EN (adds out_multi and multi_cnt).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_vec is the request vector
//   out_valid/out_ready  : output handshake
//   out_idx, out_none    : lowest-set-bit index and all-zero flag of the captured vector
//   out_multi, multi_cnt : (MULTI_HOT_CHK_EN) multi-hot flag, saturating multi-hot count
module binary_encoder
  import binary_codec_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none
`ifdef MULTI_HOT_CHK_EN
  ,
  output logic         out_multi,
  output logic [7:0]   multi_cnt
`endif
);

  enc_state_e state_q, state_d;
  logic [W-1:0] idx_q, idx_d, enc_idx;
  logic         none_q, none_d, enc_none;
  logic         accept, complete;

`ifdef MULTI_HOT_CHK_EN
  logic       multi_q, multi_d, enc_multi;
  logic [7:0] cnt_q, cnt_d;
`endif

  prio_enc #(
    .N (N)
  ) u_prio_enc (
    .vec_i   (in_vec),
    .idx_o   (enc_idx),
    .none_o  (enc_none)
`ifdef MULTI_HOT_CHK_EN
    ,
    .multi_o (enc_multi)
`endif
  );

  // Ready passes straight through from downstream so a full stage never bubbles.
  assign in_ready = (state_q == ENC_EMPTY) | out_ready;
  assign accept   = in_valid & in_ready;
  assign complete = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_EMPTY: if (accept) state_d = ENC_FULL;
      ENC_FULL:  if (complete && !accept) state_d = ENC_EMPTY;
      default:   state_d = ENC_EMPTY;
    endcase
  end

  always_comb begin
    idx_d  = accept ? enc_idx  : idx_q;
    none_d = accept ? enc_none : none_q;
`ifdef MULTI_HOT_CHK_EN
    multi_d = accept ? enc_multi : multi_q;
    cnt_d   = cnt_q;
    if (accept && enc_multi && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENC_EMPTY;
      idx_q   <= '0;
      none_q  <= 1'b0;
`ifdef MULTI_HOT_CHK_EN
      multi_q <= 1'b0;
      cnt_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
`ifdef MULTI_HOT_CHK_EN
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == ENC_FULL);
  assign out_idx   = idx_q;
  assign out_none  = none_q;
`ifdef MULTI_HOT_CHK_EN
  assign out_multi = multi_q;
  assign multi_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_binary_encoder.sv
// Scoreboard bench for binary_encoder: the driver pushes the expected result of every
// accepted vector, an independent monitor checks whatever the DUT presents.
module tb_binary_encoder;

  localparam int unsigned N = 4;
  localparam int unsigned W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_none;
`ifdef MULTI_HOT_CHK_EN
  logic         out_multi;
  logic [7:0]   multi_cnt;
`endif

  binary_encoder #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_none  (out_none)
`ifdef MULTI_HOT_CHK_EN
    ,
    .out_multi (out_multi),
    .multi_cnt (multi_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vec;
    int unsigned  idx;
    logic         none;
    logic         multi;
  } exp_t;

  exp_t sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned mcnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: isolate the lowest set bit, then find which power of two it is.
  function automatic exp_t model(input logic [N-1:0] v);
    exp_t m;
    logic [N-1:0] low;
    low     = v & (~v + 1'b1);
    m.vec   = v;
    m.idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (low == (N'(1) << k)) m.idx = k;
    end
    m.none  = (v == '0);
    m.multi = ($countones(v) > 1);
    return m;
  endfunction

  // Inputs change on the falling edge; in_ready is checked, then the accept is scored.
  task automatic drive(input logic v, input logic [N-1:0] vec, input logic rdy);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    #1;
    exp_rdy = (sb.size() == 0) || rdy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    #2;
    if (v && exp_rdy) begin
      exp_t m;
      m = model(vec);
      sb.push_back(m);
      if (m.multi && mcnt < 255) mcnt++;
    end
  endtask

  // Monitor: samples 2 time units after each falling edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
`ifdef MULTI_HOT_CHK_EN
      chk("multi_cnt", 32'(multi_cnt), mcnt);
`endif
      if (sb.size() != 0 && out_valid) begin
        chk("out_idx", 32'(out_idx), sb[0].idx);
        chk("out_none", 32'(out_none), 32'(sb[0].none));
`ifdef MULTI_HOT_CHK_EN
        chk("out_multi", 32'(out_multi), 32'(sb[0].multi));
`endif
        if ($countones(sb[0].vec) == 1)
          chk("roundtrip", 32'(N'(1) << out_idx), 32'(sb[0].vec));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    // Reset with a request pending: nothing may be captured.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'b1111;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_none", 32'(out_none), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MULTI_HOT_CHK_EN
    chk("rst_multi_cnt", 32'(multi_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // One-hot sweep at full throughput.
    for (int i = 0; i < N; i++) drive(1'b1, N'(1) << i, 1'b1);
    drive(1'b0, '0, 1'b1);

    // Backpressure: held result, ignored inputs, then pass-through accept.
    drive(1'b1, 4'b0100, 1'b0);
    repeat (3) drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0001, 1'b1);
    drive(1'b0, '0, 1'b1);

    // Zero vector and priority.
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b1010, 1'b1);
    drive(1'b0, '0, 1'b1);

    // Asynchronous reset while holding a result.
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) drive(1'b1, N'(1) << i, 1'b1);
    drive(1'b0, '0, 1'b1);

`ifdef MULTI_HOT_CHK_EN
    // Saturate the multi-hot counter, then a one-hot must leave it alone.
    repeat (300) drive(1'b1, 4'b0011, 1'b1);
    drive(1'b1, 4'b0100, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("multi_cnt_sat", 32'(multi_cnt), 32'hFF);
`endif

    // Random traffic with random backpressure.
    repeat (400) drive(1'($urandom_range(0, 1)), N'($urandom_range(0, (1 << N) - 1)),
                       1'($urandom_range(0, 3) != 0));

    // Drain.
    repeat (3) drive(1'b0, '0, 1'b1);
    chk("drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
